// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } arb_state_t;

   typedef enum logic {
      OWNER_CPU,
      OWNER_DBG
   } arb_owner_t;

   localparam int unsigned ARB_WORD_SHIFT = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/debug requesters, the arbiter and the single-ported memory.
interface mem_port_arbiter_if #(
   parameter int unsigned DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [31:0]   cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic          cpu_err;
   logic [DW-1:0] cpu_rdata;

   logic          dbg_req;
   logic          dbg_we;
   logic [31:0]   dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_gnt;
   logic          dbg_rvalid;
   logic          dbg_err;
   logic [DW-1:0] dbg_rdata;

   logic          mem_read;
   logic          mem_write;
   logic [31:0]   mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_err, cpu_rdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_err, cpu_rdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );

endinterface

// File: rtl/mem_arb_select.sv
// Winner selection between CPU and debug port. MEM_ARB_ROUND_ROBIN_EN selects strict
// alternation; otherwise CPU-first priority with a debug starvation counter.
module mem_arb_select
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       idle,
   input  logic       cpu_req,
   input  logic       dbg_req,
   output arb_owner_t winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   arb_owner_t last_owner_q, last_owner_d;

   always_comb begin
      winner = OWNER_CPU;
      if (dbg_req && (!cpu_req || last_owner_q == OWNER_CPU)) winner = OWNER_DBG;
      last_owner_d = last_owner_q;
      if (idle && (cpu_req || dbg_req)) last_owner_d = winner;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) last_owner_q <= OWNER_CPU;
      else        last_owner_q <= last_owner_d;
   end
`else
   logic [2:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      winner = OWNER_CPU;
      if (dbg_req && (!cpu_req || wait_cnt_q == 3'(STARVE_LIMIT))) winner = OWNER_DBG;
      wait_cnt_d = wait_cnt_q;
      // Counts CPU wins taken while the debug port was waiting; any other idle outcome clears it.
      if (idle) begin
         if (dbg_req && winner == OWNER_CPU) wait_cnt_d = wait_cnt_q + 3'd1;
         else                                wait_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wait_cnt_q <= '0;
      else        wait_cnt_q <= wait_cnt_d;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the CPU and a debug/loader port, one
// 3-cycle transaction at a time (grant, memory strobe, response).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned DW           = 32,
   parameter int unsigned DEPTH        = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.slave  bus
);

   arb_state_t    state_q, state_d;
   arb_owner_t    owner_q, owner_d;
   arb_owner_t    winner;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          cpu_gnt_q, cpu_gnt_d, dbg_gnt_q, dbg_gnt_d;
   logic          cpu_rvalid_q, cpu_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;
   logic          cpu_err_q, cpu_err_d, dbg_err_q, dbg_err_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
   logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic          busy_q, busy_d;
   logic          range_err;
   logic [DW-1:0] resp_data;

   mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
      .clk     (clk),
      .reset   (reset),
      .idle    (state_q == IDLE),
      .cpu_req (bus.cpu_req),
      .dbg_req (bus.dbg_req),
      .winner  (winner)
   );

   assign range_err = (32'(addr_q[31:ARB_WORD_SHIFT]) >= 32'(DEPTH)) ||
                      (addr_q[ARB_WORD_SHIFT-1:0] != '0);
   assign resp_data = (we_q || range_err) ? '0 : bus.mem_rdata;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cpu_gnt_d    = 1'b0;
      dbg_gnt_d    = 1'b0;
      cpu_rvalid_d = 1'b0;
      dbg_rvalid_d = 1'b0;
      cpu_err_d    = cpu_err_q;
      dbg_err_d    = dbg_err_q;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cpu_req || bus.dbg_req) begin
               owner_d = winner;
               state_d = ACCESS;
               if (winner == OWNER_DBG) begin
                  dbg_gnt_d = 1'b1;
                  we_d      = bus.dbg_we;
                  addr_d    = bus.dbg_addr;
                  wdata_d   = bus.dbg_wdata;
               end else begin
                  cpu_gnt_d = 1'b1;
                  we_d      = bus.cpu_we;
                  addr_d    = bus.cpu_addr;
                  wdata_d   = bus.cpu_wdata;
               end
            end
         end
         ACCESS: begin
            mem_read_d  = !we_q && !range_err;
            mem_write_d = we_q && !range_err;
            state_d     = RESP;
         end
         RESP: begin
            state_d = IDLE;
            if (owner_q == OWNER_DBG) begin
               dbg_rvalid_d = 1'b1;
               dbg_err_d    = range_err;
               dbg_rdata_d  = resp_data;
            end else begin
               cpu_rvalid_d = 1'b1;
               cpu_err_d    = range_err;
               cpu_rdata_d  = resp_data;
            end
         end
         default: state_d = IDLE;
      endcase
      // Registered outputs lag the state by a cycle, so busy also covers the rvalid cycle.
      busy_d = (state_d != IDLE) || (state_q == RESP);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         owner_q      <= OWNER_CPU;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cpu_gnt_q    <= 1'b0;
         dbg_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         cpu_err_q    <= 1'b0;
         dbg_err_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cpu_gnt_q    <= cpu_gnt_d;
         dbg_gnt_q    <= dbg_gnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dbg_rvalid_q <= dbg_rvalid_d;
         cpu_err_q    <= cpu_err_d;
         dbg_err_q    <= dbg_err_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.cpu_gnt    = cpu_gnt_q;
   assign bus.dbg_gnt    = dbg_gnt_q;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.dbg_rvalid = dbg_rvalid_q;
   assign bus.cpu_err    = cpu_err_q;
   assign bus.dbg_err    = dbg_err_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.dbg_rdata  = dbg_rdata_q;
   assign bus.mem_read   = mem_read_q;
   assign bus.mem_write  = mem_write_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants,
// memory strobes and responses by cycle; a negedge monitor compares every cycle.
module tb_mem_port_arbiter;

   localparam int unsigned DW    = 32;
   localparam int unsigned LIMIT = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.DW(DW)) bus ();

   mem_port_arbiter #(.DW(DW), .DEPTH(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Memory the arbiter actually talks to.
   logic [31:0] tb_mem [32];
   assign bus.mem_rdata = tb_mem[bus.mem_addr[6:2]];
   always @(posedge clk) if (bus.mem_write) tb_mem[bus.mem_addr[6:2]] <= bus.mem_wdata;

   typedef struct { int unsigned cyc; bit dbg; } gnt_t;
   typedef struct { int unsigned cyc; bit we; logic [31:0] addr; logic [31:0] wdata; } stb_t;
   typedef struct { int unsigned cyc; bit dbg; bit err; logic [31:0] rdata; } rsp_t;

   gnt_t gq[$];
   stb_t sq[$];
   rsp_t rq[$];

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   int unsigned free_at = 0;
   int unsigned starve = 0;
   bit          last_dbg = 1'b0;
   bit          chk_en = 1'b0;
   logic [31:0] ref_mem [32];

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   // Reference model: one transaction per 3 cycles, winner from the arbitration rules.
   bit          m_dbg, m_we, m_err;
   logic [31:0] m_a, m_d, m_r;
   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         starve = 0; last_dbg = 1'b0; free_at = 0;
      end else if (cyc >= free_at) begin
         if (bus.cpu_req || bus.dbg_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            m_dbg = bus.dbg_req && (!bus.cpu_req || !last_dbg);
            last_dbg = m_dbg;
`else
            m_dbg = bus.dbg_req && (!bus.cpu_req || starve == LIMIT);
            starve = (bus.dbg_req && !m_dbg) ? starve + 1 : 0;
`endif
            m_we  = m_dbg ? bus.dbg_we    : bus.cpu_we;
            m_a   = m_dbg ? bus.dbg_addr  : bus.cpu_addr;
            m_d   = m_dbg ? bus.dbg_wdata : bus.cpu_wdata;
            m_err = (m_a / 4 >= 32) || (m_a % 4 != 0);
            m_r   = (m_err || m_we) ? 32'h0 : ref_mem[m_a / 4];
            if (!m_err && m_we) ref_mem[m_a / 4] = m_d;
            gq.push_back('{cyc, m_dbg});
            if (!m_err) sq.push_back('{cyc + 1, m_we, m_a, m_d});
            rq.push_back('{cyc + 2, m_dbg, m_err, m_r});
            free_at = cyc + 3;
         end else begin
            starve = 0;
         end
      end
   end

   // Monitor: absence of an expected event is as much a failure as a wrong value.
   bit          e_cg, e_dg, e_rd, e_wr, e_cv, e_dv, e_err;
   logic [31:0] e_addr, e_wd, e_rdata;
   always @(negedge clk) if (chk_en) begin
      e_cg = 1'b0; e_dg = 1'b0;
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
         e_dg = gq[0].dbg; e_cg = !gq[0].dbg; void'(gq.pop_front());
      end
      chk({bus.cpu_gnt, bus.dbg_gnt} === {e_cg, e_dg}, "gnt",
          {30'b0, bus.cpu_gnt, bus.dbg_gnt}, {30'b0, e_cg, e_dg});

      e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
         e_wr = sq[0].we; e_rd = !sq[0].we; e_addr = sq[0].addr; e_wd = sq[0].wdata;
         void'(sq.pop_front());
      end
      chk({bus.mem_read, bus.mem_write} === {e_rd, e_wr}, "mem_strobe",
          {30'b0, bus.mem_read, bus.mem_write}, {30'b0, e_rd, e_wr});
      if (e_rd || e_wr) chk(bus.mem_addr === e_addr, "mem_addr", bus.mem_addr, e_addr);
      if (e_wr) chk(bus.mem_wdata === e_wd, "mem_wdata", bus.mem_wdata, e_wd);

      e_cv = 1'b0; e_dv = 1'b0; e_err = 1'b0; e_rdata = '0;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
         e_dv = rq[0].dbg; e_cv = !rq[0].dbg; e_err = rq[0].err; e_rdata = rq[0].rdata;
         void'(rq.pop_front());
      end
      chk({bus.cpu_rvalid, bus.dbg_rvalid} === {e_cv, e_dv}, "rvalid",
          {30'b0, bus.cpu_rvalid, bus.dbg_rvalid}, {30'b0, e_cv, e_dv});
      if (e_cv) begin
         chk(bus.cpu_err === e_err, "cpu_err", {31'b0, bus.cpu_err}, {31'b0, e_err});
         chk(bus.cpu_rdata === e_rdata, "cpu_rdata", bus.cpu_rdata, e_rdata);
      end
      if (e_dv) begin
         chk(bus.dbg_err === e_err, "dbg_err", {31'b0, bus.dbg_err}, {31'b0, e_err});
         chk(bus.dbg_rdata === e_rdata, "dbg_rdata", bus.dbg_rdata, e_rdata);
      end
      chk(bus.busy === (cyc < free_at), "busy", {31'b0, bus.busy}, {31'b0, (cyc < free_at)});
   end

   task automatic do_req(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
      bit got = 1'b0;
      if (!p) begin
         bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
      end else begin
         bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         got = p ? bus.dbg_gnt : bus.cpu_gnt;
      end
      chk(got, p ? "dbg_gnt_timeout" : "cpu_gnt_timeout", {31'b0, got}, 32'd1);
      if (!p) bus.cpu_req = 1'b0;
      else    bus.dbg_req = 1'b0;
   endtask

   task automatic rnd_port(input bit p, input int unsigned n, input int unsigned maxgap);
      logic [31:0] a;
      for (int i = 0; i < int'(n); i++) begin
         repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
         a = 32'($urandom_range(0, 35)) << 2;
         if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
         do_req(p, 1'($urandom_range(0, 1)), a, $urandom);
      end
   endtask

   logic [31:0] old_word;
   bit          found;

   initial begin
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
      for (int i = 0; i < 32; i++) begin
         tb_mem[i] = $urandom;
         ref_mem[i] = tb_mem[i];
      end
      #12;
      chk({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_err, bus.dbg_err,
           bus.mem_read, bus.mem_write, bus.busy} === 9'b0, "reset_flags",
          {23'b0, bus.cpu_gnt, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_err,
           bus.dbg_err, bus.mem_read, bus.mem_write, bus.busy}, 32'h0);
      chk(bus.cpu_rdata === '0, "reset_cpu_rdata", bus.cpu_rdata, 32'h0);
      chk(bus.dbg_rdata === '0, "reset_dbg_rdata", bus.dbg_rdata, 32'h0);
      chk(bus.mem_addr === '0, "reset_mem_addr", bus.mem_addr, 32'h0);
      chk(bus.mem_wdata === '0, "reset_mem_wdata", bus.mem_wdata, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      chk_en = 1'b1;

      // Loader patch then CPU read-back, followed by out-of-range reads.
      do_req(1'b1, 1'b1, 32'h14, 32'hDEADBEEF);
      do_req(1'b0, 1'b0, 32'h14, 32'h0);
      do_req(1'b0, 1'b0, 32'h80, 32'h0);
      do_req(1'b0, 1'b0, 32'h06, 32'h0);
      // CPU request held across consecutive transactions.
      do_req(1'b0, 1'b1, 32'h10, 32'hA5A5_0001);
      do_req(1'b0, 1'b0, 32'h10, 32'h0);

      fork
         rnd_port(1'b0, 40, 3);
         rnd_port(1'b1, 40, 3);
      join
      fork
         rnd_port(1'b0, 25, 0);
         rnd_port(1'b1, 25, 0);
      join

      // Reset asserted while a write strobe is on the bus.
      repeat (3) begin @(posedge clk); #1; end
      old_word = ref_mem[8];
      do_req(1'b1, 1'b1, 32'h20, 32'h1234_5678);
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         @(negedge clk);
         found = bus.mem_write;
      end
      chk(found, "rst_write_seen", {31'b0, found}, 32'd1);
      #1;
      reset = 1'b0;
      gq.delete(); sq.delete(); rq.delete();
      ref_mem[8] = old_word;
      #1;
      chk({bus.mem_write, bus.busy, bus.dbg_rvalid} === 3'b0, "rst_abort",
          {29'b0, bus.mem_write, bus.busy, bus.dbg_rvalid}, 32'h0);
      repeat (2) begin @(posedge clk); #1; end
      chk(tb_mem[8] === old_word, "rst_mem_unchanged", tb_mem[8], old_word);
      reset = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      do_req(1'b0, 1'b0, 32'h20, 32'h0);

      repeat (6) begin @(posedge clk); #1; end
      chk(gq.size() + sq.size() + rq.size() == 0, "queues_drained",
          32'(gq.size() + sq.size() + rq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
